craps_roll_controller: RTL and testbench
========================================

// Module: craps_roll_controller
// PURPOSE
//  Producer/consumer partner of the come-out evaluator. Generates two dice on a
//  roll request and drives their sum to the evaluator. Reads back the evaluator's
//  2-bit verdict on the come-out roll, then runs the point phase itself.
//  Presents dice, point and final game result to the display logic.
// PARAMETERS
//  EVAL_LAT  2  clocks from sum register update to op sample (evaluator reg + 1)
// PORTS
//  clk       in   1  system clock, all logic on posedge
//  rst_n     in   1  synchronous reset, active-low
//  roll      in   1  roll request, level sampled each edge (already debounced/synced)
//  op        in   2  evaluator verdict: 00 init, 01 reroll, 10 win, 11 lose
//  sum       out  4  die1+die2, 2..12; feeds evaluator
//  die1      out  3  first die face 1..6
//  die2      out  3  second die face 1..6
//  point     out  4  established point; 0 when none
//  result    out  2  00 playing/idle, 10 win, 11 lose (same codes as op)
//  busy      out  1  high while waiting on a verdict; rolls ignored
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): sum=0, die1=die2=1, point=0, result=00, busy=0,
//   c1=c2=0, state=IDLE. Reset wins over every other event, including mid-wait.
//  Dice counters: c1 0..5 increments every edge; c2 0..5 increments when c1 wraps
//   5->0. Together they cycle all 36 pairs every 36 clocks. Counters are never frozen.
//  States: IDLE, COME_WAIT, POINT, PT_WAIT, DONE.
//  Roll accept (roll=1 at an edge in IDLE/POINT/DONE):
//   - same edge: die1=c1+1, die2=c2+1, sum=c1+c2+2, busy=1; wait counter=0.
//   - IDLE/DONE -> COME_WAIT; also point=0 and result=00.
//   - POINT -> PT_WAIT.
//  COME_WAIT: op is sampled at edge E+EVAL_LAT, where E is the accept edge.
//   - op=10 -> result=10, DONE.
//   - op=11 -> result=11, DONE.
//   - op=01 -> point=sum, POINT.
//   - op=00 -> error case; treated as 01.
//   busy=0 on the decision edge.
//  PT_WAIT: decided at edge E+EVAL_LAT; op ignored.
//   - sum==point -> result=10, DONE.
//   - sum==7 -> result=11, DONE.
//   - else -> POINT.
//   busy=0 on the decision edge.
//  roll while busy: ignored, no queuing. roll held high re-triggers on the first
//   edge after busy falls.
//  sum, die1, die2 hold stable from the accept edge until the next accepted roll.
//  point holds through DONE until the next come-out accept.
//  Sum width: max 12 fits 4 bits; no overflow possible.
// TESTING
//  1 Reset mid-PT_WAIT -> next edge: point=0, result=00, busy=0, sum=0, state IDLE.
//  2 Roll at edge with c1=3,c2=2 -> die1=4, die2=3, sum=7, busy=1. Evaluator gives 10
//    -> at E+2: result=10, busy=0.
//  3 Come-out c1=0,c2=0 (sum 2), op=11 -> result=11. Repeat with sum 3 and sum 12
//    -> result=11.
//  4 Come-out sum 6, op=01 -> point=6. Then a point roll sum 8 -> POINT, result=00.
//    Then a point roll sum 6 -> result=10.
//  5 Point=4, point roll sum 7 -> result=11, point stays 4. Next roll -> point=0.
//  6 roll pulsed at E+1 during COME_WAIT -> dice unchanged, one decision only.
//    roll held high -> new accept on edge E+EVAL_LAT+1.

Source files
------------

// File: rtl/craps_roll_controller.sv
// craps_roll_controller
//   Rolls two dice when asked. It drives their sum to the come-out evaluator and
//   reads back the evaluator's verdict on the come-out roll. It then plays the
//   point phase itself and presents the dice, the point and the final result for
//   display.
//
// Ports
//   clk     in   system clock, all logic on posedge
//   rst_n   in   synchronous reset, active-low
//   roll    in   roll request, level sampled on every edge
//   op      in   [1:0] evaluator verdict: 00 init, 01 reroll, 10 win, 11 lose
//   sum     out  [3:0] die1+die2 (2..12), feeds the evaluator
//   die1    out  [2:0] first die face 1..6
//   die2    out  [2:0] second die face 1..6
//   point   out  [3:0] established point, 0 when none
//   result  out  [1:0] 00 playing/idle, 10 win, 11 lose
//   busy    out  high while waiting on a decision; rolls are ignored meanwhile
module craps_roll_controller #(
    parameter int EVAL_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       roll,
    input  logic [1:0] op,
    output logic [3:0] sum,
    output logic [2:0] die1,
    output logic [2:0] die2,
    output logic [3:0] point,
    output logic [1:0] result,
    output logic       busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_COME_WAIT = 3'd1;
    localparam logic [2:0] S_POINT     = 3'd2;
    localparam logic [2:0] S_PT_WAIT   = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_WIN  = 2'b10;
    localparam logic [1:0] RES_LOSE = 2'b11;

    // The wait counter is cleared on the accept edge, so the decision edge is the
    // one on which it already holds EVAL_LAT-1.
    localparam logic [3:0] WAIT_LAST = 4'(EVAL_LAT - 1);

    logic [2:0] state;
    logic [2:0] c1;
    logic [2:0] c2;
    logic [3:0] wcnt;
    logic       accept;
    logic       decide;

    // Sum of two zero-based counters, as a 1-based dice total.
    function automatic logic [3:0] dice_sum(input logic [2:0] a, input logic [2:0] b);
        return {1'b0, a} + {1'b0, b} + 4'd2;
    endfunction

    // Free-running dice counters. They visit all 36 pairs every 36 clocks and are
    // never frozen, so the roll timing alone picks the pair.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c1 <= 3'd0;
            c2 <= 3'd0;
        end else if (c1 == 3'd5) begin
            c1 <= 3'd0;
            c2 <= (c2 == 3'd5) ? 3'd0 : c2 + 3'd1;
        end else begin
            c1 <= c1 + 3'd1;
        end
    end

    always_comb begin
        accept = roll && ((state == S_IDLE) || (state == S_POINT) || (state == S_DONE));
        decide = ((state == S_COME_WAIT) || (state == S_PT_WAIT)) && (wcnt == WAIT_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            sum    <= 4'd0;
            die1   <= 3'd1;
            die2   <= 3'd1;
            point  <= 4'd0;
            result <= RES_NONE;
            busy   <= 1'b0;
            wcnt   <= 4'd0;
        end else if (accept) begin
            die1  <= c1 + 3'd1;
            die2  <= c2 + 3'd1;
            sum   <= dice_sum(c1, c2);
            busy  <= 1'b1;
            wcnt  <= 4'd0;
            if (state == S_POINT) begin
                state <= S_PT_WAIT;
            end else begin
                // A new game starts: forget the previous point and outcome.
                state  <= S_COME_WAIT;
                point  <= 4'd0;
                result <= RES_NONE;
            end
        end else if (decide) begin
            busy <= 1'b0;
            if (state == S_COME_WAIT) begin
                // An init verdict (00) is an evaluator fault; play on as a reroll.
                case (op)
                    2'b10: begin
                        result <= RES_WIN;
                        state  <= S_DONE;
                    end
                    2'b11: begin
                        result <= RES_LOSE;
                        state  <= S_DONE;
                    end
                    default: begin
                        point <= sum;
                        state <= S_POINT;
                    end
                endcase
            end else if (sum == point) begin
                result <= RES_WIN;
                state  <= S_DONE;
            end else if (sum == 4'd7) begin
                result <= RES_LOSE;
                state  <= S_DONE;
            end else begin
                state <= S_POINT;
            end
        end else if ((state == S_COME_WAIT) || (state == S_PT_WAIT)) begin
            wcnt <= wcnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_craps_roll_controller.sv
module tb_craps_roll_controller;

    localparam int EVAL_LAT = 2;

    logic       clk;
    logic       rst_n;
    logic       roll;
    logic [1:0] op;
    logic [3:0] sum;
    logic [2:0] die1;
    logic [2:0] die2;
    logic [3:0] point;
    logic [1:0] result;
    logic       busy;

    craps_roll_controller #(.EVAL_LAT(EVAL_LAT)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .roll   (roll),
        .op     (op),
        .sum    (sum),
        .die1   (die1),
        .die2   (die2),
        .point  (point),
        .result (result),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int d1;
        int d2;
        int s;
        int pt;
        int res;
    } txn_t;

    txn_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " sum"},    int'(sum),    0);
        chk({tag, " die1"},   int'(die1),   1);
        chk({tag, " die2"},   int'(die2),   1);
        chk({tag, " point"},  int'(point),  0);
        chk({tag, " result"}, int'(result), 0);
        chk({tag, " busy"},   int'(busy),   0);
    endtask

    // Monitor: a falling busy marks a finished decision; pop and compare.
    initial begin : monitor
        bit prev_busy;
        int busy_cycles;
        txn_t t;
        prev_busy   = 1'b0;
        busy_cycles = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_busy   = 1'b0;
                busy_cycles = 0;
            end else begin
                if (busy) busy_cycles++;
                if (prev_busy && !busy) begin
                    if (q.size() == 0) begin
                        chk("unexpected decision", 1, 0);
                    end else begin
                        t = q.pop_front();
                        chk("die1",   int'(die1),   t.d1);
                        chk("die2",   int'(die2),   t.d2);
                        chk("sum",    int'(sum),    t.s);
                        chk("point",  int'(point),  t.pt);
                        chk("result", int'(result), t.res);
                        chk("busy length", busy_cycles, EVAL_LAT);
                    end
                    busy_cycles = 0;
                end
                prev_busy = busy;
            end
        end
    end

    // Stimulus plus reference model. The model knows the dice from the number of
    // edges since reset and applies the game rules directly to the totals.
    initial begin : stim
        int   k;
        bit   mbusy;
        int   wleft;
        bit   in_point;
        bit   come;
        int   mpoint;
        int   mres;
        int   planned_op;
        bit   did_rst;
        txn_t t;

        rst_n = 1'b0;
        roll  = 1'b0;
        op    = 2'b00;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");

        rst_n    = 1'b1;
        k        = 0;
        mbusy    = 1'b0;
        wleft    = 0;
        in_point = 1'b0;
        come     = 1'b0;
        mpoint   = 0;
        mres     = 0;
        planned_op = 0;
        did_rst  = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) @(negedge clk);

            // One reset while a point roll is about to be decided.
            if (!did_rst && cyc > 1000 && mbusy && !come && wleft == 1) begin
                did_rst = 1'b1;
                rst_n   = 1'b0;
                roll    = 1'b1;
                op      = 2'($urandom_range(0, 3));
                void'(q.pop_back());
                @(negedge clk);
                chk_reset_state("midwait reset");
                rst_n    = 1'b1;
                k        = 0;
                mbusy    = 1'b0;
                wleft    = 0;
                in_point = 1'b0;
                mpoint   = 0;
                mres     = 0;
            end

            roll = ($urandom_range(0, 2) != 0);
            op   = 2'($urandom_range(0, 3));

            if (mbusy) begin
                if (wleft == 1) begin
                    op    = 2'(planned_op);
                    mbusy = 1'b0;
                end
                wleft--;
            end else if (roll) begin
                t.d1 = (k % 6) + 1;
                t.d2 = ((k / 6) % 6) + 1;
                t.s  = t.d1 + t.d2;
                planned_op = $urandom_range(0, 3);
                come = !in_point;
                if (come) begin
                    mpoint = 0;
                    if (planned_op == 2)      mres = 2;
                    else if (planned_op == 3) mres = 3;
                    else begin
                        mres   = 0;
                        mpoint = t.s;
                    end
                end else begin
                    if (t.s == mpoint)  mres = 2;
                    else if (t.s == 7)  mres = 3;
                    else                mres = 0;
                end
                in_point = (mres == 0);
                t.pt  = mpoint;
                t.res = mres;
                q.push_back(t);
                mbusy = 1'b1;
                wleft = EVAL_LAT;
            end
            k++;
        end

        @(negedge clk);
        roll = 1'b0;
        repeat (6) @(negedge clk);
        chk("pending decisions", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
